// File: rtl/edge_pkg.sv
// Shared types, Sobel kernel weights and the magnitude saturation helper
// for the line_edge_detect slice.
package edge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  // Sobel kernel weights: outer taps and centre tap of the 1-2-1 smoother.
  localparam int SOBEL_K_EDGE   = 1;
  localparam int SOBEL_K_CENTRE = 2;

  function automatic logic [31:0] saturate(input logic [31:0] val,
                                           input int unsigned pix_w);
    logic [31:0] max_val;
    max_val = (32'd1 << pix_w) - 32'd1;
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/sobel3x3.sv
// Combinational 3x3 Sobel operator: |Gx| + |Gy| saturated to PIX_W bits.
// Window index is row*3 + col; row 0 is the oldest line, col 0 the leftmost.
module sobel3x3
  import edge_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic [8:0][PIX_W-1:0] win_i,
  output logic [PIX_W-1:0]      mag_o
);

  localparam int unsigned GW = PIX_W + 4;
  localparam logic signed [GW-1:0] KE = GW'(SOBEL_K_EDGE);
  localparam logic signed [GW-1:0] KC = GW'(SOBEL_K_CENTRE);

  logic signed [GW-1:0] p [9];
  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic        [GW-1:0] ax;
  logic        [GW-1:0] ay;
  logic        [GW-1:0] mag;

  always_comb begin
    for (int unsigned i = 0; i < 9; i++) begin
      p[i] = signed'({4'b0000, win_i[i]});
    end
    gx  = (KE * p[2] + KC * p[5] + KE * p[8]) - (KE * p[0] + KC * p[3] + KE * p[6]);
    gy  = (KE * p[6] + KC * p[7] + KE * p[8]) - (KE * p[0] + KC * p[1] + KE * p[2]);
    ax  = gx[GW-1] ? unsigned'(-gx) : unsigned'(gx);
    ay  = gy[GW-1] ? unsigned'(-gy) : unsigned'(gy);
    mag = ax + ay;
    mag_o = PIX_W'(saturate(32'(mag), PIX_W));
  end

endmodule

// File: rtl/line_edge_detect.sv
// Streaming 3x3 Sobel edge detector over a raster video stream with frame sync.
// Build option: define EDGE_THRESHOLD_EN to binarise the magnitude against THRESH.
module line_edge_detect
  import edge_pkg::*;
#(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned THRESH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             frame_err
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  fsm_state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d, x_eff;
  logic [YW-1:0] y_q, y_d, y_eff;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic frame_err_q, frame_err_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;

  logic [PIX_W-1:0] lb1_q [WIDTH];
  logic [PIX_W-1:0] lb2_q [WIDTH];
  logic [PIX_W-1:0] col_a_q [3];
  logic [PIX_W-1:0] col_b_q [3];
  logic [PIX_W-1:0] col_new [3];
  logic [8:0][PIX_W-1:0] win;
  logic [PIX_W-1:0] mag;
  logic [PIX_W-1:0] edge_val;
  logic accept;
  logic emit;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

  // The window keeps only the two older columns in registers; the newest
  // column is the live pixel plus the line-buffer reads, so the registered
  // output appears one cycle after the transfer.
  always_comb begin
    accept = in_valid && in_ready;
    emit   = accept && ((state_q == RUN) || in_sof);
    x_eff  = in_sof ? '0 : x_q;
    y_eff  = in_sof ? '0 : y_q;
    col_new[0] = lb2_q[x_eff];
    col_new[1] = lb1_q[x_eff];
    col_new[2] = in_pixel;
    for (int unsigned r = 0; r < 3; r++) begin
      win[r*3 + 0] = col_a_q[r];
      win[r*3 + 1] = col_b_q[r];
      win[r*3 + 2] = col_new[r];
    end
  end

  sobel3x3 #(
    .PIX_W(PIX_W)
  ) u_sobel (
    .win_i(win),
    .mag_o(mag)
  );

`ifdef EDGE_THRESHOLD_EN
  always_comb begin
    edge_val = (32'(mag) >= 32'(THRESH)) ? '1 : '0;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^32'(THRESH);
  always_comb begin
    edge_val = mag;
  end
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_last_d  = out_last_q;
    frame_err_d = frame_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept && in_sof) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && in_sof && ((x_q != '0) || (y_q != '0))) begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_pixel_d = ((x_eff < X_TWO) || (y_eff < Y_TWO)) ? '0 : edge_val;
      out_last_d  = (x_eff == X_LAST) && (y_eff == Y_LAST);
      if (x_eff == X_LAST) begin
        x_d = '0;
        y_d = (y_eff == Y_LAST) ? '0 : y_eff + YW'(1);
      end else begin
        x_d = x_eff + XW'(1);
        y_d = y_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage left unreset: stale contents only reach pixels masked by the border rule.
  always_ff @(posedge clk) begin
    if (emit) begin
      lb2_q[x_eff] <= lb1_q[x_eff];
      lb1_q[x_eff] <= in_pixel;
      for (int unsigned r = 0; r < 3; r++) begin
        col_a_q[r] <= col_b_q[r];
        col_b_q[r] <= col_new[r];
      end
    end
  end

endmodule

// File: tb/tb_line_edge_detect.sv
// Scoreboard bench for line_edge_detect at WIDTH=8, HEIGHT=4, PIX_W=8, THRESH=128.
module tb_line_edge_detect;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
  localparam int unsigned P = 8;

  typedef struct packed {
    logic       last;
    logic [7:0] pix;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] in_pixel;
  logic         in_sof;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out_pixel;
  logic         out_last;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  line_edge_detect #(
    .WIDTH(W), .HEIGHT(H), .PIX_W(P), .THRESH(128)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid && ready now.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none at %0t", out_pixel, $time);
      end else begin
        mon_e = sb.pop_front();
        check("out_pixel", 32'(out_pixel), 32'(mon_e.pix));
        check("out_last", 32'(out_last), 32'(mon_e.last));
      end
    end
  end

  // Hand-computed edge value at x=4,5 for a 0 -> b vertical step (|Gx| = 4b).
  function automatic logic [7:0] step_exp(input logic [7:0] b);
`ifdef EDGE_THRESHOLD_EN
    case (b)
      8'h10:   return 8'h00;
      default: return 8'hFF;
    endcase
`else
    case (b)
      8'h10:   return 8'h40;
      default: return 8'hFF;
    endcase
`endif
  endfunction

  task automatic send(input logic [7:0] p, input logic s, input bit push, input exp_t e);
    int n;
    if (push) sb.push_back(e);
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready !== 1'b1 && n < 100);
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got %0b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit step, input logic [7:0] b, input logic sof0);
    exp_t e;
    logic [7:0] p;
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        p      = step ? ((x >= 4) ? b : 8'h00) : b;
        e.pix  = (step && y >= 2 && (x == 4 || x == 5)) ? step_exp(b) : 8'h00;
        e.last = (x == int'(W) - 1) && (y == int'(H) - 1);
        send(p, (x == 0 && y == 0) ? sof0 : 1'b0, 1'b1, e);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic stall();
    logic [7:0] held;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        held = out_pixel;
        check("stall_out_valid", 32'(out_valid), 32'd1);
      end
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hold", 32'(out_pixel), 32'(held));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    exp_t z;
    z = '0;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // IDLE: pixels without sof are swallowed
    for (int i = 0; i < 3; i++) send(8'h55, 1'b0, 1'b0, z);
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_output", 32'(out_valid), 32'd0);

    send_frame(1'b0, 8'h80, 1'b1);
    drain();
    check("flat_frame_err", 32'(frame_err), 32'd0);

    send_frame(1'b1, 8'hFF, 1'b1);
    drain();
    check("step_frame_err", 32'(frame_err), 32'd0);

    fork
      send_frame(1'b1, 8'hFF, 1'b1);
      begin
        repeat (21) @(posedge clk);
        #1;
        stall();
      end
    join
    drain();

    // sof at (3,1): 11 pixels of a flat frame, then a full step frame restarting there
    for (int i = 0; i < 11; i++) send(8'h80, (i == 0) ? 1'b1 : 1'b0, 1'b1, z);
    check("pre_err_frame_err", 32'(frame_err), 32'd0);
    send_frame(1'b1, 8'hFF, 1'b1);
    drain();
    check("sof_err_set", 32'(frame_err), 32'd1);
    send_frame(1'b0, 8'h80, 1'b1);
    drain();
    check("sof_err_sticky", 32'(frame_err), 32'd1);

    // reset mid-frame after 10 pixels
    for (int i = 0; i < 10; i++) send(8'h80, (i == 0) ? 1'b1 : 1'b0, 1'b1, z);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send_frame(1'b0, 8'h80, 1'b1);
    drain();
    send_frame(1'b1, 8'hFF, 1'b1);
    drain();
    check("post_rst_frame_err", 32'(frame_err), 32'd0);

    send_frame(1'b1, 8'h10, 1'b1);
    drain();
    send_frame(1'b1, 8'h40, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
